// File: rtl/cfg_cardinfo_resp_if.sv
// Host-side request/response bundle for the card-info register window.
//   req_valid/req_ready : request handshake (host -> block)
//   req_wr              : 1 = write, 0 = read
//   req_addr            : DWORD index into the 16-entry window
//   req_wdata           : write data
//   rsp_valid/rsp_ack   : response handshake (block -> host)
//   rsp_data            : read data, 0 for writes and errors
//   rsp_err             : unmapped index or write to a read-only index
// master = host side, slave = cfg_cardinfo_resp side.
interface cfg_cardinfo_resp_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [3:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ack;
  logic [31:0] rsp_data;
  logic        rsp_err;

  modport master (
    output req_valid, req_wr, req_addr, req_wdata, rsp_ack,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata, rsp_ack,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/cfg_cardinfo_resp.sv
// Card-info register window responder.
// Serves one request at a time through a three-state FSM
// (IDLE -> LOOKUP -> RESP). Read-only indices expose static card
// information; index 6 is a writable scratch register and index 7 a
// saturating count of successful reads (cleared by writing it).
// Ports:
//   clock, reset          : single rising-edge clock, synchronous active-high reset
//   bus (slave modport)   : request/response handshake, see cfg_cardinfo_resp_if
//   ci_*                  : static card-info sources, sampled in LOOKUP
module cfg_cardinfo_resp #(
  parameter logic [31:0] SCRATCH_INIT = 32'h0000_0000,
  parameter int          CNT_W        = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  cfg_cardinfo_resp_if.slave    bus,
  input  logic [15:0]           ci_subsystem_id,
  input  logic [15:0]           ci_subsystem_vendor_id,
  input  logic [63:0]           ci_serial_number,
  input  logic [63:0]           ci_bar0_size,
  input  logic [7:0]            ci_tl_major,
  input  logic [7:0]            ci_tl_minor
);

  typedef enum logic [1:0] {IDLE, LOOKUP, RESP} state_t;

  state_t            state_q, state_d;
  logic              wr_q, wr_d;
  logic [3:0]        addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;
  logic [31:0]       scratch_q, scratch_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       cnt_ext;

  assign cnt_ext = 32'(cnt_q);

  // Read mux for the eight mapped indices.
  function automatic logic [31:0] read_word(
    input logic [2:0]  idx,
    input logic [15:0] sub_id,
    input logic [15:0] sub_vid,
    input logic [63:0] serial,
    input logic [63:0] bar0,
    input logic [7:0]  tl_maj,
    input logic [7:0]  tl_min,
    input logic [31:0] scratch,
    input logic [31:0] cnt
  );
    logic [31:0] w;
    case (idx)
      3'd0:    w = {sub_id, sub_vid};
      3'd1:    w = serial[31:0];
      3'd2:    w = serial[63:32];
      3'd3:    w = bar0[31:0];
      3'd4:    w = bar0[63:32];
      3'd5:    w = {16'h0000, tl_maj, tl_min};
      3'd6:    w = scratch;
      default: w = cnt;
    endcase
    return w;
  endfunction

  // Outputs are forced inactive while reset is held, even before the
  // registers have settled into their reset values.
  assign bus.req_ready = (state_q == IDLE) && !reset;
  assign bus.rsp_valid = (state_q == RESP) && !reset;
  assign bus.rsp_data  = reset ? 32'h0 : rsp_data_q;
  assign bus.rsp_err   = reset ? 1'b0  : rsp_err_q;

  always_comb begin
    state_d    = state_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    scratch_d  = scratch_q;
    cnt_d      = cnt_q;

    case (state_q)
      IDLE: begin
        if (bus.req_valid && bus.req_ready) begin
          wr_d    = bus.req_wr;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          state_d = LOOKUP;
        end
      end

      LOOKUP: begin
        rsp_data_d = 32'h0;
        rsp_err_d  = 1'b0;
        if (addr_q[3]) begin
          // Indices 8..15 are unmapped for both reads and writes.
          rsp_err_d = 1'b1;
        end else if (!wr_q) begin
          // Index 7 returns the count as it stood before this read.
          rsp_data_d = read_word(addr_q[2:0], ci_subsystem_id,
                                 ci_subsystem_vendor_id, ci_serial_number,
                                 ci_bar0_size, ci_tl_major, ci_tl_minor,
                                 scratch_q, cnt_ext);
          if (cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          case (addr_q[2:0])
            3'd6:    scratch_d = wdata_q;
            3'd7:    cnt_d     = '0;
            default: rsp_err_d = 1'b1;
          endcase
        end
        state_d = RESP;
      end

      RESP: begin
        if (bus.rsp_ack) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      rsp_data_q <= 32'h0;
      rsp_err_q  <= 1'b0;
      scratch_q  <= SCRATCH_INIT;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      scratch_q  <= scratch_d;
      cnt_q      <= cnt_d;
    end
  end

  // Captured request fields are only consumed in LOOKUP, so they need no reset.
  always_ff @(posedge clock) begin
    wr_q    <= wr_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

endmodule

// File: tb/tb_cfg_cardinfo_resp.sv
// Directed bench for cfg_cardinfo_resp. Two instances run the same
// stimulus: A with the default 16-bit read counter, B with a 2-bit
// counter so that saturation shows up after a handful of reads.
module tb_cfg_cardinfo_resp;

  localparam logic [31:0] SINIT = 32'hC0FF_EE00;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_wr;
  logic [3:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_ack;
  logic [15:0] ci_subsystem_id;
  logic [15:0] ci_subsystem_vendor_id;
  logic [63:0] ci_serial_number;
  logic [63:0] ci_bar0_size;
  logic [7:0]  ci_tl_major;
  logic [7:0]  ci_tl_minor;

  int total;
  int bad;

  cfg_cardinfo_resp_if bus_a();
  cfg_cardinfo_resp_if bus_b();

  assign bus_a.req_valid = req_valid;
  assign bus_a.req_wr    = req_wr;
  assign bus_a.req_addr  = req_addr;
  assign bus_a.req_wdata = req_wdata;
  assign bus_a.rsp_ack   = rsp_ack;
  assign bus_b.req_valid = req_valid;
  assign bus_b.req_wr    = req_wr;
  assign bus_b.req_addr  = req_addr;
  assign bus_b.req_wdata = req_wdata;
  assign bus_b.rsp_ack   = rsp_ack;

  cfg_cardinfo_resp #(.SCRATCH_INIT(SINIT), .CNT_W(16)) dut_a (
    .clock                  (clock),
    .reset                  (reset),
    .bus                    (bus_a),
    .ci_subsystem_id        (ci_subsystem_id),
    .ci_subsystem_vendor_id (ci_subsystem_vendor_id),
    .ci_serial_number       (ci_serial_number),
    .ci_bar0_size           (ci_bar0_size),
    .ci_tl_major            (ci_tl_major),
    .ci_tl_minor            (ci_tl_minor)
  );

  cfg_cardinfo_resp #(.SCRATCH_INIT(SINIT), .CNT_W(2)) dut_b (
    .clock                  (clock),
    .reset                  (reset),
    .bus                    (bus_b),
    .ci_subsystem_id        (ci_subsystem_id),
    .ci_subsystem_vendor_id (ci_subsystem_vendor_id),
    .ci_serial_number       (ci_serial_number),
    .ci_bar0_size           (ci_bar0_size),
    .ci_tl_major            (ci_tl_major),
    .ci_tl_minor            (ci_tl_minor)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one transaction; enters and leaves on a falling edge.
  task automatic xact(input logic wr, input logic [3:0] addr, input logic [31:0] wdata,
                      output logic [31:0] da, output logic ea,
                      output logic [31:0] db, output logic eb, output int lat);
    int n;
    n = 0;
    while (!(bus_a.req_ready && bus_b.req_ready) && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk("ready_wait_ok", 64'(n < 20), 64'd1);
    req_wr    = wr;
    req_addr  = addr;
    req_wdata = wdata;
    req_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    lat = 1;
    while (!bus_a.rsp_valid && lat < 20) begin
      @(negedge clock);
      lat++;
    end
    da = bus_a.rsp_data;
    ea = bus_a.rsp_err;
    db = bus_b.rsp_data;
    eb = bus_b.rsp_err;
    rsp_ack = 1'b1;
    @(negedge clock);
    rsp_ack = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [3:0] addr, input logic [31:0] exp_a,
                    input logic [31:0] exp_b, input logic exp_err);
    logic [31:0] da, db;
    logic        ea, eb;
    int          lat;
    xact(1'b0, addr, 32'h0, da, ea, db, eb, lat);
    chk({tag, "_lat"},    64'(lat), 64'd2);
    chk({tag, "_data_a"}, 64'(da),  64'(exp_a));
    chk({tag, "_data_b"}, 64'(db),  64'(exp_b));
    chk({tag, "_err_a"},  64'(ea),  64'(exp_err));
    chk({tag, "_err_b"},  64'(eb),  64'(exp_err));
  endtask

  task automatic wrt(input string tag, input logic [3:0] addr, input logic [31:0] wdata,
                     input logic exp_err);
    logic [31:0] da, db;
    logic        ea, eb;
    int          lat;
    xact(1'b1, addr, wdata, da, ea, db, eb, lat);
    chk({tag, "_lat"},    64'(lat), 64'd2);
    chk({tag, "_data_a"}, 64'(da),  64'd0);
    chk({tag, "_data_b"}, 64'(db),  64'd0);
    chk({tag, "_err_a"},  64'(ea),  64'(exp_err));
    chk({tag, "_err_b"},  64'(eb),  64'(exp_err));
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_wr    = 1'b0;
    req_addr  = 4'h0;
    req_wdata = 32'h0;
    rsp_ack   = 1'b0;
    ci_subsystem_id        = 16'h0666;
    ci_subsystem_vendor_id = 16'h1014;
    ci_serial_number       = 64'hDEAD_BEEF_0123_4567;
    ci_bar0_size           = 64'h0000_0004_FFF0_0000;
    ci_tl_major            = 8'h01;
    ci_tl_minor            = 8'h02;

    // Reset state
    repeat (3) @(negedge clock);
    chk("rst_ready",    64'(bus_a.req_ready), 64'd0);
    chk("rst_valid",    64'(bus_a.rsp_valid), 64'd0);
    chk("rst_data",     64'(bus_a.rsp_data),  64'd0);
    chk("rst_err",      64'(bus_a.rsp_err),   64'd0);
    chk("rst_ready_b",  64'(bus_b.req_ready), 64'd0);
    reset = 1'b0;
    @(negedge clock);
    chk("post_rst_ready", 64'(bus_a.req_ready), 64'd1);
    chk("post_rst_valid", 64'(bus_a.rsp_valid), 64'd0);

    // Counter starts at zero, scratch at its init value
    rd("r7_reset",  4'd7, 32'd0, 32'd0, 1'b0);
    rd("r6_init",   4'd6, SINIT, SINIT, 1'b0);
    rd("r0_ids",    4'd0, 32'h0666_1014, 32'h0666_1014, 1'b0);
    wrt("w7_clr1",  4'd7, 32'hFFFF_FFFF, 1'b0);

    // Serial halves, then counter shows two reads
    rd("r1_ser_lo", 4'd1, 32'h0123_4567, 32'h0123_4567, 1'b0);
    rd("r2_ser_hi", 4'd2, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0);
    rd("r7_two",    4'd7, 32'd2, 32'd2, 1'b0);

    // Remaining read-only words; B saturates at 3
    rd("r3_bar_lo", 4'd3, 32'hFFF0_0000, 32'hFFF0_0000, 1'b0);
    rd("r4_bar_hi", 4'd4, 32'h0000_0004, 32'h0000_0004, 1'b0);
    rd("r5_tl",     4'd5, 32'h0000_0102, 32'h0000_0102, 1'b0);
    rd("r7_six",    4'd7, 32'd6, 32'd3, 1'b0);

    // Scratch write/read, read-only write rejected
    wrt("w6_scr",   4'd6, 32'hA5A5_5A5A, 1'b0);
    rd("r6_scr",    4'd6, 32'hA5A5_5A5A, 32'hA5A5_5A5A, 1'b0);
    wrt("w3_ro",    4'd3, 32'h1234_5678, 1'b1);
    rd("r3_keep",   4'd3, 32'hFFF0_0000, 32'hFFF0_0000, 1'b0);

    // Unmapped indices: error, no data, no counter change
    rd("r9_unmap",  4'd9,  32'd0, 32'd0, 1'b1);
    rd("r15_unmap", 4'd15, 32'd0, 32'd0, 1'b1);
    wrt("w12_unmap", 4'd12, 32'h5555_AAAA, 1'b1);
    rd("r7_nine",   4'd7, 32'd9, 32'd3, 1'b0);

    // Clear then saturate: 5 reads leave B at 3
    wrt("w7_clr2",  4'd7, 32'h0, 1'b0);
    rd("r7_zero",   4'd7, 32'd0, 32'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      rd("r0_loop", 4'd0, 32'h0666_1014, 32'h0666_1014, 1'b0);
    end
    rd("r7_sat",    4'd7, 32'd5, 32'd3, 1'b0);
    wrt("w7_clr3",  4'd7, 32'h0, 1'b0);
    rd("r7_clr",    4'd7, 32'd0, 32'd0, 1'b0);

    // Backpressure: ci sampled in LOOKUP, response held without ack
    req_wr    = 1'b0;
    req_addr  = 4'd0;
    req_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    ci_subsystem_id = 16'h0777;
    @(negedge clock);
    for (int i = 0; i < 10; i++) begin
      chk("stall_valid", 64'(bus_a.rsp_valid), 64'd1);
      chk("stall_data",  64'(bus_a.rsp_data),  64'h0777_1014);
      chk("stall_ready", 64'(bus_a.req_ready), 64'd0);
      @(negedge clock);
    end
    rsp_ack = 1'b1;
    @(negedge clock);
    rsp_ack = 1'b0;
    chk("stall_done_ready", 64'(bus_a.req_ready), 64'd1);
    chk("stall_done_valid", 64'(bus_a.rsp_valid), 64'd0);
    ci_subsystem_id = 16'h0666;

    // Reset during LOOKUP of a scratch write
    req_wr    = 1'b1;
    req_addr  = 4'd6;
    req_wdata = 32'h1111_2222;
    req_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    reset     = 1'b1;
    @(negedge clock);
    chk("midrst_valid1", 64'(bus_a.rsp_valid), 64'd0);
    chk("midrst_ready1", 64'(bus_a.req_ready), 64'd0);
    @(negedge clock);
    chk("midrst_valid2", 64'(bus_a.rsp_valid), 64'd0);
    reset = 1'b0;
    @(negedge clock);
    chk("midrst_ready_after", 64'(bus_a.req_ready), 64'd1);
    chk("midrst_valid_after", 64'(bus_a.rsp_valid), 64'd0);
    rd("r6_after_rst", 4'd6, SINIT, SINIT, 1'b0);
    rd("r7_after_rst", 4'd7, 32'd1, 32'd1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
